// File: rtl/sram_confreg_responder.sv
// Purpose : SRAM-style bus responder. It serves a word-addressed RAM and a small confreg window (LED, switch, timer, scratch).
// Latency : 1 cycle. Read data is registered from the request cycle and holds until the next request.
// Backpressure: none. A request can be accepted every cycle, and there is no stall or ready signal.
//
// Ports:
//   clk, resetn         - sole clock (rising edge); asynchronous active-low reset
//   sram_en             - request valid this cycle
//   sram_wen[3:0]       - byte write enables (0 = read)
//   sram_addr[31:0]     - byte address ([1:0] ignored for RAM)
//   sram_wdata[31:0]    - write data
//   sram_rdata[31:0]    - registered read data (read-first on write cycles)
//   led[15:0]           - LED register
//   switch[7:0]         - asynchronous board switches (two-flop synchronized)
//
// Optional feature macro: CONFREG_TIMER_EN. When it is defined, the free-running TIMER register
// at offset 0xf008 is built. When it is undefined, that offset reads 0 and ignores writes.

module sram_confreg_responder #(
  parameter int          ADDR_W    = 10,
  parameter logic [15:0] CONF_BASE = 16'hbfaf
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic [15:0] led,
  input  logic [7:0]  switch
);

  localparam logic [15:0] OFF_LED     = 16'hf000;
  localparam logic [15:0] OFF_SWITCH  = 16'hf004;
  localparam logic [15:0] OFF_TIMER   = 16'hf008;
  localparam logic [15:0] OFF_SCRATCH = 16'hf00c;

  // Byte-lane merge: each enabled byte is taken from the new data, and the other bytes keep their old value.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [31:0] ram_mem [2**ADDR_W];   // not reset; contents survive resetn

  logic [31:0] rdata_q,   rdata_d;
  logic [15:0] led_q,     led_d;
  logic [31:0] scratch_q, scratch_d;
  logic [7:0]  sw_meta_q, sw_meta_d;
  logic [7:0]  sw_sync_q, sw_sync_d;
`ifdef CONFREG_TIMER_EN
  logic [31:0] timer_q,   timer_d;
`endif

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic              conf_sel;
  logic [ADDR_W-1:0] ram_idx;
  logic [15:0]       conf_off;
  logic              wr_en;
  logic [31:0]       ram_rd;
  logic [31:0]       conf_rd;
  logic [31:0]       rd_val;

  always_comb begin
    conf_sel = (sram_addr[31:16] == CONF_BASE);
    ram_idx  = sram_addr[ADDR_W+1:2];   // higher address bits alias
    conf_off = sram_addr[15:0];
    wr_en    = sram_en && (sram_wen != 4'b0000);
    ram_rd   = ram_mem[ram_idx];
  end

  // Confreg read mux. Unmapped offsets read as zero.
  always_comb begin
    conf_rd = 32'h0;
    case (conf_off)
      OFF_LED:     conf_rd = {16'h0, led_q};
      OFF_SWITCH:  conf_rd = {24'h0, sw_sync_q};
`ifdef CONFREG_TIMER_EN
      OFF_TIMER:   conf_rd = timer_q;
`endif
      OFF_SCRATCH: conf_rd = scratch_q;
      default:     conf_rd = 32'h0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_val    = conf_sel ? conf_rd : ram_rd;
    // The read value is sampled before the write. A write cycle therefore returns the old contents.
    rdata_d   = sram_en ? rd_val : rdata_q;

    led_d     = led_q;
    scratch_d = scratch_q;
    if (wr_en && conf_sel) begin
      if (conf_off == OFF_LED) begin
        led_d = byte_merge({16'h0, led_q}, sram_wdata, sram_wen) >> 0;
      end
      if (conf_off == OFF_SCRATCH) begin
        scratch_d = byte_merge(scratch_q, sram_wdata, sram_wen);
      end
    end

    sw_meta_d = switch;
    sw_sync_d = sw_meta_q;
  end

`ifdef CONFREG_TIMER_EN
  // A write in the same cycle takes priority over the increment, so the written value is the next value.
  always_comb begin
    timer_d = timer_q + 32'd1;
    if (wr_en && conf_sel && (conf_off == OFF_TIMER)) begin
      timer_d = byte_merge(timer_q, sram_wdata, sram_wen);
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q   <= 32'h0;
      led_q     <= 16'h0;
      scratch_q <= 32'h0;
      sw_meta_q <= 8'h0;
      sw_sync_q <= 8'h0;
    end else begin
      rdata_q   <= rdata_d;
      led_q     <= led_d;
      scratch_q <= scratch_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
    end
  end

`ifdef CONFREG_TIMER_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_q <= 32'h0;
    end else begin
      timer_q <= timer_d;
    end
  end
`endif

  // RAM write port with per-byte enables. There is no reset, so the array maps onto plain SRAM.
  always_ff @(posedge clk) begin
    if (wr_en && !conf_sel) begin
      for (int b = 0; b < 4; b++) begin
        if (sram_wen[b]) ram_mem[ram_idx][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
    end
  end

  assign sram_rdata = rdata_q;
  assign led        = led_q;

endmodule

// File: tb/tb_sram_confreg_responder.sv
module tb_sram_confreg_responder;

`ifdef CONFREG_TIMER_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif

  localparam logic [31:0] LEDA = 32'hbfaff000;
  localparam logic [31:0] SWA  = 32'hbfaff004;
  localparam logic [31:0] TMA  = 32'hbfaff008;
  localparam logic [31:0] SCA  = 32'hbfaff00c;
  localparam logic [31:0] UNA  = 32'hbfaff010;

  logic        clk = 1'b0;
  logic        resetn;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic [15:0] led;
  logic [7:0]  sw_in;

  sram_confreg_responder dut (
    .clk        (clk),
    .resetn     (resetn),
    .sram_en    (sram_en),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .led        (led),
    .switch     (sw_in)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [31:0] mem [int];            // word index -> contents (only words that are known)
  logic [15:0] m_led;
  logic [31:0] m_scratch;
  logic [31:0] m_rd;
  bit          m_rd_known;
  logic [31:0] tbase, tcyc, cyc;     // timer = tbase + cycles elapsed since tcyc
  logic [7:0]  sw_pipe [$];          // [0] is the value visible now, [1] is the value visible after the next edge

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] t_exp(input logic [31:0] v);
    return TIMER_ON ? v : 32'h0;
  endfunction

  task automatic model_reset();
    m_led = 16'h0; m_scratch = 32'h0; m_rd = 32'h0; m_rd_known = 1'b1;
    tbase = 32'h0; tcyc = cyc;
    sw_pipe.delete(); sw_pipe.push_back(8'h0); sw_pipe.push_back(8'h0);
  endtask

  // Apply one request for one cycle and advance the model across that edge.
  // Return at posedge+1, when the registered outputs are stable.
  task automatic step(input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] rv, tnow;
    bit          known;
    int          idx;
    sram_en = en; sram_wen = wen; sram_addr = addr; sram_wdata = wd;
    tnow  = tbase + (cyc - tcyc);
    idx   = int'(addr[11:2]);
    rv    = 32'h0;
    known = 1'b1;
    if (addr[31:16] == 16'hbfaf) begin
      case (addr[15:0])
        16'hf000: rv = {16'h0, m_led};
        16'hf004: rv = {24'h0, sw_pipe[0]};
        16'hf008: rv = t_exp(tnow);
        16'hf00c: rv = m_scratch;
        default:  rv = 32'h0;
      endcase
    end else if (mem.exists(idx)) rv = mem[idx];
    else known = 1'b0;
    if (en) begin
      m_rd = rv; m_rd_known = known;
      if (wen != 4'h0) begin
        if (addr[31:16] == 16'hbfaf) begin
          case (addr[15:0])
            16'hf000: m_led = merge({16'h0, m_led}, wd, wen) & 32'hffff;
            16'hf008: if (TIMER_ON) begin tbase = merge(tnow, wd, wen); tcyc = cyc + 1; end
            16'hf00c: m_scratch = merge(m_scratch, wd, wen);
            default: ;
          endcase
        end else if (known || wen == 4'hf) mem[idx] = merge(rv, wd, wen);
      end
    end
    void'(sw_pipe.pop_front());
    sw_pipe.push_back(sw_in);
    cyc = cyc + 1;
    @(posedge clk); #1;
  endtask

  task automatic model_check(input string tag);
    if (m_rd_known) chk({tag, "_rdata"}, sram_rdata, m_rd);
    chk({tag, "_led"}, {16'h0, led}, {16'h0, m_led});
  endtask

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [$];

  initial begin
    resetn = 1'b0; sram_en = 1'b0; sram_wen = 4'h0; sram_addr = 32'h0; sram_wdata = 32'h0;
    sw_in = 8'h3c; cyc = 32'h0;
    model_reset();

    tbl.push_back('{1'b1, 4'hf, 32'h10,   32'h12345678, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 4'h0, 32'h10,   32'h0,        1'b1, 32'h12345678});
    tbl.push_back('{1'b1, 4'h5, 32'h10,   32'haabbccdd, 1'b1, 32'h12345678});
    tbl.push_back('{1'b1, 4'h0, 32'h10,   32'h0,        1'b1, 32'h12bb56dd});
    tbl.push_back('{1'b1, 4'h0, 32'h1010, 32'h0,        1'b1, 32'h12bb56dd});
    tbl.push_back('{1'b1, 4'hf, SCA,      32'h1,        1'b1, 32'h0});
    tbl.push_back('{1'b0, 4'h0, SCA,      32'h0,        1'b1, 32'h0});
    tbl.push_back('{1'b0, 4'hf, 32'h10,   32'h55,       1'b1, 32'h0});
    tbl.push_back('{1'b0, 4'h0, LEDA,     32'h0,        1'b1, 32'h0});
    tbl.push_back('{1'b1, 4'h0, SCA,      32'h0,        1'b1, 32'h1});
    tbl.push_back('{1'b1, 4'hf, LEDA,     32'hffffa5a5, 1'b1, 32'h0});
    tbl.push_back('{1'b1, 4'h0, LEDA,     32'h0,        1'b1, 32'h0000a5a5});
    tbl.push_back('{1'b1, 4'h0, SWA,      32'h0,        1'b1, 32'h3c});
    tbl.push_back('{1'b1, 4'hf, SWA,      32'hff,       1'b1, 32'h3c});
    tbl.push_back('{1'b1, 4'h0, SWA,      32'h0,        1'b1, 32'h3c});
    tbl.push_back('{1'b1, 4'hf, UNA,      32'hdeadbeef, 1'b1, 32'h0});
    tbl.push_back('{1'b1, 4'h0, UNA,      32'h0,        1'b1, 32'h0});
    tbl.push_back('{1'b1, 4'hf, TMA,      32'hfffffffe, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 4'h0, TMA,      32'h0,        1'b1, t_exp(32'hfffffffe)});
    tbl.push_back('{1'b1, 4'h0, TMA,      32'h0,        1'b1, t_exp(32'hffffffff)});
    tbl.push_back('{1'b1, 4'h0, TMA,      32'h0,        1'b1, 32'h0});
    tbl.push_back('{1'b1, 4'h0, 32'h10,   32'h0,        1'b1, 32'h12bb56dd});

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata", sram_rdata, 32'h0);
    chk("reset_led", {16'h0, led}, 32'h0);
    resetn = 1'b1;

    // Directed table
    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].wen, tbl[i].addr, tbl[i].wdata);
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rdata", i), sram_rdata, tbl[i].exp_rd);
      model_check($sformatf("tbl%0d", i));
    end
    chk("led_after_write", {16'h0, led}, 32'h0000a5a5);

    // Asynchronous reset asserted between edges while a read is in flight
    sram_en = 1'b1; sram_wen = 4'h0; sram_addr = LEDA;
    #3;
    resetn = 1'b0;
    #1;
    chk("async_rst_rdata", sram_rdata, 32'h0);
    chk("async_rst_led", {16'h0, led}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    sram_en = 1'b0;
    resetn = 1'b1;
    model_reset();
    chk("post_rst_rdata", sram_rdata, 32'h0);
    step(1'b1, 4'h0, TMA, 32'h0);
    chk("post_rst_timer", sram_rdata, 32'h0);
    step(1'b1, 4'h0, 32'h10, 32'h0);
    chk("ram_survives_rst", sram_rdata, 32'h12bb56dd);
    step(1'b1, 4'h0, SWA, 32'h0);
    chk("sw_sync_settled", sram_rdata, 32'h3c);
    step(1'b1, 4'h0, SCA, 32'h0);
    chk("scratch_rst", sram_rdata, 32'h0);

    // Randomized traffic against the reference model
    for (int w = 0; w < 8; w++) begin
      step(1'b1, 4'hf, 32'(w * 4), $urandom);
      model_check("rinit");
    end
    for (int n = 0; n < 600; n++) begin
      logic        en;
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [15:0] offs [5];
      offs[0] = 16'hf000; offs[1] = 16'hf004; offs[2] = 16'hf008; offs[3] = 16'hf00c; offs[4] = 16'hf010;
      en  = ($urandom_range(3) != 0);
      wen = ($urandom_range(4) < 2) ? 4'h0 : 4'($urandom);
      if ($urandom_range(9) < 6) begin
        addr = $urandom;
        addr[11:2] = 10'($urandom_range(7));
        if (addr[31:16] == 16'hbfaf) addr[31] = 1'b0;
      end else begin
        addr = {16'hbfaf, offs[$urandom_range(4)]};
      end
      if (n == 300) sw_in = 8'($urandom);
      step(en, wen, addr, $urandom);
      model_check("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
